// File: rtl/mtx_res_collector.sv
// rtl/mtx_res_collector.sv - round-robin merge of per-channel result streams into one tagged output
module mtx_res_collector #(
    parameter int NUM_CH        = 32,
    parameter int DATA_WIDTH    = 32,
    localparam int CH_ID_WIDTH  = $clog2(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    output logic [NUM_CH-1:0]              ch_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [CH_ID_WIDTH-1:0]         out_ch,
    input  logic                           out_ready,
    output logic [31:0]                    beat_cnt
);

    // Output register occupancy
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [CH_ID_WIDTH-1:0] LAST_CH = CH_ID_WIDTH'(NUM_CH - 1);

    logic [0:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q,  data_d;
    logic [CH_ID_WIDTH-1:0] ch_q,    ch_d;
    logic [CH_ID_WIDTH-1:0] ptr_q,   ptr_d;
    logic [31:0]            beat_q,  beat_d;

    logic [DATA_WIDTH-1:0]  data_arr [NUM_CH];
    logic [NUM_CH-1:0]      hi_mask;
    logic [NUM_CH-1:0]      hi_valid;
    logic [CH_ID_WIDTH-1:0] hi_idx;
    logic [CH_ID_WIDTH-1:0] lo_idx;
    logic [CH_ID_WIDTH-1:0] grant_idx;
    logic                   any_valid;
    logic                   reg_free;
    logic                   chan_hs;
    logic                   out_hs;

    // Unpack the flat channel data bus into one word per channel
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            data_arr[i] = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Channels at or above the pointer get first pick; the rest are the wrap-around tail
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hi_mask[i] = (CH_ID_WIDTH'(i) >= ptr_q);
        end
        hi_valid = ch_valid & hi_mask;
    end

    // Lowest-index search in both halves; scanning downward leaves the lowest hit
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hi_valid[i]) begin
                hi_idx = CH_ID_WIDTH'(i);
            end
            if (ch_valid[i]) begin
                lo_idx = CH_ID_WIDTH'(i);
            end
        end
    end

    // Grant selection and handshake qualifiers; out_ready feeds ch_ready through reg_free
    always_comb begin
        any_valid = |ch_valid;
        grant_idx = (|hi_valid) ? hi_idx : lo_idx;
        reg_free  = (state_q == ST_EMPTY) || out_ready;
        chan_hs   = reset_n && reg_free && any_valid;
        out_hs    = (state_q == ST_FULL) && out_ready;
    end

    // One-hot accept toward the granted channel, zero when nothing can be taken
    always_comb begin
        ch_ready = '0;
        if (chan_hs) begin
            ch_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state: reload on a channel handshake, drain on an output-only handshake
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        if (out_hs) begin
            beat_d = beat_q + 32'd1;
        end
        if (chan_hs) begin
            state_d = ST_FULL;
            data_d  = data_arr[grant_idx];
            ch_d    = grant_idx;
            ptr_d   = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_ID_WIDTH'(1);
        end else if (out_hs) begin
            state_d = ST_EMPTY;
        end
    end

    // State registers; reset drops any held beat without counting it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_mtx_res_collector.sv
// tb/tb_mtx_res_collector.sv - scoreboard bench for mtx_res_collector
module tb_mtx_res_collector;
    localparam int NUM_CH = 32;
    localparam int DW     = 32;
    localparam int CW     = 5;

    typedef struct {
        int             ch;
        logic [DW-1:0]  data;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NUM_CH-1:0]    ch_valid = '0;
    logic [NUM_CH*DW-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_ready = 1'b0;
    logic [31:0]          beat_cnt;

    logic [DW-1:0] dat [NUM_CH];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    beat_t         exp_q[$];
    bit            m_full;
    int            m_ptr;
    logic [31:0]   m_beats;
    int            m_last_ch;
    logic [DW-1:0] m_last_data;

    mtx_res_collector #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ch_valid  (ch_valid),
        .ch_data   (ch_data),
        .ch_ready  (ch_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i*DW +: DW] = dat[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin as stated: first valid index scanning ptr, ptr+1, ... modulo NUM_CH
    function automatic int model_grant();
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_valid[(m_ptr + k) % NUM_CH]) return (m_ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    // Called just after a falling edge with inputs set; checks, advances the model, runs one clock
    task automatic step();
        bit                free;
        int                g;
        logic [NUM_CH-1:0] exp_ready;
        #1;
        exp_ready = '0;
        g    = -1;
        free = !m_full || out_ready;
        if (reset_n) begin
            g = model_grant();
            if (free && g >= 0) exp_ready[g] = 1'b1;
        end
        if (check_en) begin
            check("ch_ready", 64'(ch_ready), 64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(m_full));
            check("beat_cnt", 64'(beat_cnt), 64'(m_beats));
            check("out_ch_hold", 64'(out_ch), 64'(m_last_ch));
            check("out_data_hold", 64'(out_data), 64'(m_last_data));
        end
        if (!reset_n) begin
            m_full      = 1'b0;
            m_ptr       = 0;
            m_beats     = '0;
            m_last_ch   = 0;
            m_last_data = '0;
            exp_q.delete();
        end else begin
            if (m_full && out_ready) m_beats = m_beats + 32'd1;
            if (free && g >= 0) begin
                exp_q.push_back('{g, dat[g]});
                m_ptr       = (g + 1) % NUM_CH;
                m_full      = 1'b1;
                m_last_ch   = g;
                m_last_data = dat[g];
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: compare the presented beat with the oldest expected one
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (check_en && reset_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty: got beat ch %0d data 0x%0h expected none", out_ch, out_data);
                end else begin
                    e = exp_q[0];
                    check("sb_ch", 64'(out_ch), 64'(e.ch));
                    check("sb_data", 64'(out_data), 64'(e.data));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) dat[i] = '0;
        m_full = 1'b0; m_ptr = 0; m_beats = '0; m_last_ch = 0; m_last_data = '0;

        // Reset held with all channels valid and downstream ready
        reset_n   = 1'b0;
        ch_valid  = '1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_en = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        #1 check("first_grant", 64'(ch_ready), 64'h1);
        step();

        // Single channel 5
        do_reset();
        dat[5]    = 32'hA5A5_0005;
        ch_valid  = 32'h0000_0020;
        out_ready = 1'b1;
        #1 check("single_ready", 64'(ch_ready), 64'h20);
        repeat (6) step();

        // Full load: every channel valid, data = index
        do_reset();
        for (int i = 0; i < NUM_CH; i++) dat[i] = DW'(i);
        ch_valid = '1;
        repeat (65) step();
        #1 check("full_beats64", 64'(beat_cnt), 64'd64);

        // Backpressure with channels 3 and 7
        do_reset();
        for (int i = 0; i < NUM_CH; i++) dat[i] = $urandom;
        ch_valid  = 32'h0000_0088;
        out_ready = 1'b0;
        repeat (11) step();
        out_ready = 1'b1;
        #1 check("bp_grant7", 64'(ch_ready), 64'h80);
        repeat (3) step();

        // Wrap: grant 30, then only 31 and 2
        ch_valid = 32'h4000_0000;
        step();
        ch_valid = 32'h8000_0004;
        repeat (2) step();
        ch_valid = '1;
        #1 check("wrap_ptr3", 64'(ch_ready), 64'h8);
        step();

        // Mid-operation reset with a beat held and beat_cnt at 17
        do_reset();
        out_ready = 1'b1;
        ch_valid  = 32'h0000_0200;
        repeat (18) step();
        ch_valid  = '0;
        out_ready = 1'b0;
        #1 check("mid_cnt17", 64'(beat_cnt), 64'd17);
        check("mid_held", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1 check("mid_valid0", 64'(out_valid), 64'd0);
        check("mid_cnt0", 64'(beat_cnt), 64'd0);
        ch_valid  = '1;
        out_ready = 1'b1;
        #1 check("mid_grant0", 64'(ch_ready), 64'h1);
        step();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            case ($urandom % 3)
                0:       ch_valid = $urandom;
                1:       ch_valid = $urandom & $urandom & $urandom;
                default: ch_valid = '1;
            endcase
            for (int i = 0; i < NUM_CH; i++) dat[i] = $urandom;
            out_ready = ($urandom % 4) != 0;
            reset_n   = ($urandom % 200) != 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
